// File: rtl/usr_pkg.sv
// ---------------------------------------------------------------------------
// usr_pkg
// Shared definitions for the universal shift register.
//   usr_mode_t : 2-bit operation select (hold / shift right / shift left / load)
//   DIR_RIGHT / DIR_LEFT : encoding of the remembered shift direction
// No ports (package).
// ---------------------------------------------------------------------------
package usr_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHR  = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_LOAD = 2'b11
    } usr_mode_t;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

endpackage

// File: rtl/usr_shift_counter.sv
// ---------------------------------------------------------------------------
// usr_shift_counter
// Counts shifts modulo WIDTH and emits a one-cycle word_done strobe in the
// cycle after the shift that completes a word.
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous active-high reset
//   en         in   clock enable; when low the count holds and the strobe clears
//   shift      in   a shift (either direction) happens on this edge
//   clear      in   a parallel load happens on this edge; restarts the count
//   bit_count  out  shifts since the last load/reset, modulo WIDTH
//   word_done  out  one-cycle strobe after the WIDTH-th shift
// ---------------------------------------------------------------------------
module usr_shift_counter
    import usr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic                     shift,
    input  logic                     clear,
    output logic [$clog2(WIDTH)-1:0] bit_count,
    output logic                     word_done
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic [CNT_W-1:0] r_count;
    logic             r_done;

    // The strobe defaults low on every edge that is not a wrapping shift,
    // including disabled edges, so it can never be stretched.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
            r_done  <= 1'b0;
        end else if (!en) begin
            r_done  <= 1'b0;
        end else if (clear) begin
            r_count <= '0;
            r_done  <= 1'b0;
        end else if (shift) begin
            if (r_count == LAST) begin
                r_count <= '0;
                r_done  <= 1'b1;
            end else begin
                r_count <= r_count + 1'b1;
                r_done  <= 1'b0;
            end
        end else begin
            r_done  <= 1'b0;
        end
    end

    assign bit_count = r_count;
    assign word_done = r_done;

endmodule

// File: rtl/universal_shift_register.sv
// ---------------------------------------------------------------------------
// universal_shift_register
// WIDTH-bit shift register with left/right shift, synchronous parallel load,
// clock enable and a shift counter with word-complete strobe. Used as a
// serialiser/deserialiser between serial links and word-wide datapaths.
// Optional feature macro: USR_ROTATE_EN adds the rotate port; with rotate=1
// shifts recirculate the outgoing bit instead of taking data_in.
// Ports:
//   clk           in   rising-edge clock
//   reset         in   synchronous active-high reset (priority over en/mode)
//   en            in   clock enable; 0 freezes state and clears word_done
//   mode          in   00 hold, 01 shift right, 10 shift left, 11 load
//   data_in       in   serial input bit
//   parallel_in   in   load value
//   rotate        in   (USR_ROTATE_EN only) rotate instead of shift
//   data_out      out  bit that leaves on the next shift in current direction
//   parallel_out  out  register contents
//   bit_count     out  shifts since last load/reset, modulo WIDTH
//   word_done     out  one-cycle strobe after a full word has been shifted
// ---------------------------------------------------------------------------
module universal_shift_register
    import usr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic [1:0]               mode,
    input  logic                     data_in,
    input  logic [WIDTH-1:0]         parallel_in,
`ifdef USR_ROTATE_EN
    input  logic                     rotate,
`endif
    output logic                     data_out,
    output logic [WIDTH-1:0]         parallel_out,
    output logic [$clog2(WIDTH)-1:0] bit_count,
    output logic                     word_done
);

    logic [WIDTH-1:0] r_q;
    logic             r_dir;

    usr_mode_t w_mode;
    logic      w_shr_in;
    logic      w_shl_in;
    logic      w_shift;
    logic      w_load;

    assign w_mode = usr_mode_t'(mode);

`ifdef USR_ROTATE_EN
    // Rotation feeds back the bit that is about to fall off the far end.
    assign w_shr_in = rotate ? r_q[0]       : data_in;
    assign w_shl_in = rotate ? r_q[WIDTH-1] : data_in;
`else
    assign w_shr_in = data_in;
    assign w_shl_in = data_in;
`endif

    assign w_shift = (w_mode == MODE_SHR) || (w_mode == MODE_SHL);
    assign w_load  = (w_mode == MODE_LOAD);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q   <= '0;
            r_dir <= DIR_RIGHT;
        end else if (en) begin
            case (w_mode)
                MODE_SHR: begin
                    r_q   <= {w_shr_in, r_q[WIDTH-1:1]};
                    r_dir <= DIR_RIGHT;
                end
                MODE_SHL: begin
                    r_q   <= {r_q[WIDTH-2:0], w_shl_in};
                    r_dir <= DIR_LEFT;
                end
                MODE_LOAD: begin
                    // Direction is remembered across loads.
                    r_q   <= parallel_in;
                end
                default: begin
                end
            endcase
        end
    end

    usr_shift_counter #(
        .WIDTH (WIDTH)
    ) u_counter (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .shift     (w_shift),
        .clear     (w_load),
        .bit_count (bit_count),
        .word_done (word_done)
    );

    // The only combinational output: the bit on the exit side of q.
    assign data_out     = (r_dir == DIR_LEFT) ? r_q[WIDTH-1] : r_q[0];
    assign parallel_out = r_q;

endmodule
